// File: rtl/mem_op_sequencer.sv
// Hardwired fetch/execute sequencer for the ld/ldi/st instruction class.
// Optional macro MEM_READY_HS_EN replaces the fixed MEM_WAIT hold with a mem_ready handshake.
module mem_op_sequencer #(
    parameter int OPC_W    = 5,
    parameter int MEM_WAIT = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
`ifdef MEM_READY_HS_EN
    input  logic             mem_ready,
`endif
    input  logic [OPC_W-1:0] opcode,
    output logic             PCout,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDR_read,
    output logic             MDRout,
    output logic             IRin,
    output logic             PCin,
    output logic             IncPC,
    output logic             Gra,
    output logic             Grb,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Yin,
    output logic             Cout,
    output logic             ZHighIn,
    output logic             ZLowIn,
    output logic             ZLowout,
    output logic             RAM_write,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0000,
        S_T0   = 4'b0111,
        S_T1   = 4'b1000,
        S_T2   = 4'b1001,
        S_T3   = 4'b1010,
        S_T4   = 4'b1011,
        S_T5   = 4'b1100,
        S_T6   = 4'b1101,
        S_T7   = 4'b1110
    } state_e;

    localparam logic [OPC_W-1:0] OP_LD  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ST  = OPC_W'(2);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             op_legal;
    logic             mem_done;

    // T3 decodes the live opcode; it is only captured on the edge that leaves T3.
    assign op_legal = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);

`ifdef MEM_READY_HS_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = (cnt_q == 4'(MEM_WAIT));
`endif

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            S_IDLE: state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_done) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                opc_d   = opcode;
                state_d = op_legal ? S_T4 : S_T0;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (opc_q == OP_LDI) ? S_T0 : S_T6;
            S_T6:   if ((opc_q != OP_LD) || mem_done) state_d = S_T7;
            S_T7:   state_d = S_T0;
            default: state_d = S_IDLE;
        endcase
        // Counter restarts on every state change so each memory state gets a full hold.
        cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
        if (!run) begin
            state_d = state_q;
            cnt_d   = cnt_q;
            opc_d   = opc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
        end
    end

    assign state = state_q;

    always_comb begin
        PCout = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDR_read = 1'b0;
        MDRout = 1'b0; IRin = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        Yin = 1'b0; Cout = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0;
        ZLowout = 1'b0; RAM_write = 1'b0; instr_done = 1'b0; illegal = 1'b0;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; end
            S_T1: begin MDRin = 1'b1; MDR_read = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; end
            S_T3: begin
                if (op_legal) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; end
            S_T5: begin
                ZLowout = 1'b1;
                if (opc_q == OP_LDI) begin
                    Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (opc_q == OP_LD) MDR_read = 1'b1;
                else begin Gra = 1'b1; Rout = 1'b1; end
            end
            S_T7: begin
                instr_done = 1'b1;
                if (opc_q == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else begin
                    RAM_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
